chip8_mem_arbiter: RTL and testbench

- Shares the single-port Chip-8 RAM (4 KB, byte-wide, synchronous read) between three requesters:
  - the SPI program uploader (write-only);
  - the blitter (sprite fetch and framebuffer read-modify-write);
  - the CPU core (opcode fetch and load/store).
- Sits inside the chip8 machine, between the RAM macro and its clients.
- Applies fixed top priority to the uploader, and round-robin between CPU and blitter.
- Locks the CPU and blitter out entirely while an upload is in progress.

---
 rtl/chip8_mem_arbiter_if.sv | 62 ++++++
 rtl/chip8_mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_chip8_mem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chip8_mem_arbiter_if.sv
// Bus bundle between the Chip-8 RAM arbiter, its three clients and the RAM macro.
//   uploading            : program upload in progress (gates CPU and blitter)
//   up_req/addr/wdata    : uploader write request, up_ack completion pulse
//   cpu_*                : CPU request, write enable, address, data, ack, read data
//   blt_*                : blitter request group, same shape as cpu_*
//   ram_addr/we/wdata    : RAM macro drive, ram_rdata its read data
//   busy, grant_id       : status / debug (0 none, 1 upload, 2 cpu, 3 blitter)
// master = arbiter side, slave = clients + RAM side.
interface chip8_mem_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic              uploading;
    logic              up_req;
    logic [ADDR_W-1:0] up_addr;
    logic [DATA_W-1:0] up_wdata;
    logic              up_ack;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              blt_req;
    logic              blt_we;
    logic [ADDR_W-1:0] blt_addr;
    logic [DATA_W-1:0] blt_wdata;
    logic              blt_ack;
    logic [DATA_W-1:0] blt_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              busy;
    logic [1:0]        grant_id;

    modport master (
        input  uploading,
        input  up_req, up_addr, up_wdata,
        output up_ack,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  blt_req, blt_we, blt_addr, blt_wdata,
        output blt_ack, blt_rdata,
        output ram_addr, ram_we, ram_wdata,
        input  ram_rdata,
        output busy, grant_id
    );

    modport slave (
        output uploading,
        output up_req, up_addr, up_wdata,
        input  up_ack,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output blt_req, blt_we, blt_addr, blt_wdata,
        input  blt_ack, blt_rdata,
        input  ram_addr, ram_we, ram_wdata,
        output ram_rdata,
        input  busy, grant_id
    );
endinterface

// File: rtl/chip8_mem_arbiter.sv
// Shares the single-port Chip-8 RAM between the SPI uploader, the CPU and the
// blitter. Uploader has fixed top priority; CPU and blitter alternate when both
// ask, and are locked out while an upload is in progress.
// Ports:
//   clk : system clock
//   res : synchronous active-high reset
//   bus : chip8_mem_arbiter_if.master (client handshakes, RAM drive, status)
//
// state  | meaning
// IDLE   | choose a winner, latch its request onto ram_*
// ACCESS | ram_* held; ram_we only in the first cycle; wait RAM_LAT cycles
// ACK    | read data valid; on leaving, pulse winner's ack and capture rdata
//
// The ack pulse is high in the first IDLE cycle after ACK, so a requester that
// keeps req high is sampled again at the end of its ack cycle (RAM_LAT+2 cycles
// per access).
module chip8_mem_arbiter #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8,
    parameter int RAM_LAT = 1
) (
    input logic                 clk,
    input logic                 res,
    chip8_mem_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_UP   = 2'd1;
    localparam logic [1:0] G_CPU  = 2'd2;
    localparam logic [1:0] G_BLT  = 2'd3;
    localparam logic [1:0] LAT_LOAD = 2'(RAM_LAT - 1);

    state_t            state_q;
    logic [1:0]        cnt_q;
    logic [1:0]        grant_q;
    logic              last_blt_q;   // 1: blitter was the last CPU/blitter winner
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;         // RAM strobe, first ACCESS cycle only
    logic              acc_we_q;     // access is a write, kept for the whole access
    logic [DATA_W-1:0] wdata_q;
    logic              up_ack_q;
    logic              cpu_ack_q;
    logic              blt_ack_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] blt_rdata_q;

    logic              cpu_elig;
    logic              blt_elig;
    logic [1:0]        grant_d;

    always_comb begin
        cpu_elig = bus.cpu_req && !bus.uploading;
        blt_elig = bus.blt_req && !bus.uploading;
        grant_d  = G_NONE;
        if (bus.up_req) begin
            grant_d = G_UP;
        end else if (cpu_elig && blt_elig) begin
            grant_d = last_blt_q ? G_CPU : G_BLT;
        end else if (cpu_elig) begin
            grant_d = G_CPU;
        end else if (blt_elig) begin
            grant_d = G_BLT;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            grant_q     <= G_NONE;
            last_blt_q  <= 1'b1;
            addr_q      <= '0;
            we_q        <= 1'b0;
            acc_we_q    <= 1'b0;
            wdata_q     <= '0;
            up_ack_q    <= 1'b0;
            cpu_ack_q   <= 1'b0;
            blt_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            blt_rdata_q <= '0;
        end else begin
            up_ack_q  <= 1'b0;
            cpu_ack_q <= 1'b0;
            blt_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    grant_q <= grant_d;
                    we_q    <= 1'b0;
                    if (grant_d != G_NONE) begin
                        state_q <= ACCESS;
                        cnt_q   <= LAT_LOAD;
                        case (grant_d)
                            G_UP: begin
                                addr_q   <= bus.up_addr;
                                wdata_q  <= bus.up_wdata;
                                we_q     <= 1'b1;
                                acc_we_q <= 1'b1;
                            end
                            G_CPU: begin
                                addr_q     <= bus.cpu_addr;
                                wdata_q    <= bus.cpu_wdata;
                                we_q       <= bus.cpu_we;
                                acc_we_q   <= bus.cpu_we;
                                last_blt_q <= 1'b0;
                            end
                            default: begin
                                addr_q     <= bus.blt_addr;
                                wdata_q    <= bus.blt_wdata;
                                we_q       <= bus.blt_we;
                                acc_we_q   <= bus.blt_we;
                                last_blt_q <= 1'b1;
                            end
                        endcase
                    end
                end
                ACCESS: begin
                    we_q <= 1'b0;
                    if (cnt_q == 2'd0) begin
                        state_q <= ACK;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                ACK: begin
                    state_q <= IDLE;
                    case (grant_q)
                        G_UP:  up_ack_q <= 1'b1;
                        G_CPU: begin
                            cpu_ack_q <= 1'b1;
                            if (!acc_we_q) cpu_rdata_q <= bus.ram_rdata;
                        end
                        G_BLT: begin
                            blt_ack_q <= 1'b1;
                            if (!acc_we_q) blt_rdata_q <= bus.ram_rdata;
                        end
                        default: ;
                    endcase
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ram_addr  = addr_q;
    assign bus.ram_we    = we_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.up_ack    = up_ack_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.blt_ack   = blt_ack_q;
    assign bus.blt_rdata = blt_rdata_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.grant_id  = grant_q;
endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Bench for chip8_mem_arbiter: one instance with RAM_LAT=1 and one with
// RAM_LAT=3, each with a behavioural synchronous RAM. Stimulus pushes the
// expected ack (who, cycle, read data) into a per-instance queue; a monitor
// pops and compares whenever an ack is seen.
module tb_chip8_mem_arbiter;
    logic clk = 1'b0;
    logic res;
    always #5 clk = ~clk;

    chip8_mem_arbiter_if #(.ADDR_W(12), .DATA_W(8)) bus1 ();
    chip8_mem_arbiter_if #(.ADDR_W(12), .DATA_W(8)) bus3 ();

    chip8_mem_arbiter #(.ADDR_W(12), .DATA_W(8), .RAM_LAT(1)) dut1 (
        .clk(clk), .res(res), .bus(bus1));
    chip8_mem_arbiter #(.ADDR_W(12), .DATA_W(8), .RAM_LAT(3)) dut3 (
        .clk(clk), .res(res), .bus(bus3));

    // RAM models with backdoor preload port
    logic [7:0]  mem1 [0:4095];
    logic [7:0]  mem3 [0:4095];
    logic [7:0]  rd1;
    logic [7:0]  p3 [0:2];
    logic        pl_we1, pl_we3;
    logic [11:0] pl_addr;
    logic [7:0]  pl_data;

    always @(posedge clk) begin
        if (pl_we1) mem1[pl_addr] <= pl_data;
        else if (bus1.ram_we) mem1[bus1.ram_addr] <= bus1.ram_wdata;
        rd1 <= mem1[bus1.ram_addr];
    end
    assign bus1.ram_rdata = rd1;

    always @(posedge clk) begin
        if (pl_we3) mem3[pl_addr] <= pl_data;
        else if (bus3.ram_we) mem3[bus3.ram_addr] <= bus3.ram_wdata;
        p3[0] <= mem3[bus3.ram_addr];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign bus3.ram_rdata = p3[2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int who;
        int cyc;
        int rd;
        bit chk;
    } exp_t;
    exp_t q1[$];
    exp_t q3[$];

    task automatic push(input int d, input int who, input int c, input int rd, input bit chk);
        exp_t e;
        e.who = who; e.cyc = c; e.rd = rd; e.chk = chk;
        if (d == 1) q1.push_back(e);
        else q3.push_back(e);
    endtask

    task automatic mon_pop(input int d, input int who, input int rdv);
        exp_t e;
        if ((d == 1 && q1.size() == 0) || (d == 3 && q3.size() == 0)) begin
            total++;
            bad++;
            $display("FAIL unexpected_ack d%0d: got ack from requester %0d at cycle %0d want none",
                     d, who, cyc);
            return;
        end
        if (d == 1) e = q1.pop_front();
        else e = q3.pop_front();
        check($sformatf("ack_who_d%0d", d), who, e.who);
        check($sformatf("ack_cycle_d%0d_w%0d", d, who), cyc, e.cyc);
        if (e.chk) check($sformatf("ack_rdata_d%0d_w%0d", d, who), rdv, e.rd);
    endtask

    always @(negedge clk) begin
        if (bus1.up_ack)  mon_pop(1, 1, 0);
        if (bus1.cpu_ack) mon_pop(1, 2, int'(bus1.cpu_rdata));
        if (bus1.blt_ack) mon_pop(1, 3, int'(bus1.blt_rdata));
        if (bus3.up_ack)  mon_pop(3, 1, 0);
        if (bus3.cpu_ack) mon_pop(3, 2, int'(bus3.cpu_rdata));
        if (bus3.blt_ack) mon_pop(3, 3, int'(bus3.blt_rdata));
    end

    function automatic logic ack_of(input int d, input int who);
        if (d == 1) begin
            case (who)
                1: return bus1.up_ack;
                2: return bus1.cpu_ack;
                default: return bus1.blt_ack;
            endcase
        end
        case (who)
            1: return bus3.up_ack;
            2: return bus3.cpu_ack;
            default: return bus3.blt_ack;
        endcase
    endfunction

    task automatic wait_ack(input int d, input int who, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack_of(d, who) && n < 40);
        if (!ack_of(d, who)) begin
            total++;
            bad++;
            $display("FAIL %s: no ack after %0d cycles, want ack", name, n);
        end
    endtask

    task automatic preload(input int d, input int addr, input int data);
        @(negedge clk);
        pl_addr = 12'(addr);
        pl_data = 8'(data);
        if (d == 1) pl_we1 = 1'b1;
        else pl_we3 = 1'b1;
        @(negedge clk);
        pl_we1 = 1'b0;
        pl_we3 = 1'b0;
    endtask

    task automatic check_reset(input int d, input string tag);
        int acks, busy, we, gid, addr, wd, crd, brd;
        if (d == 1) begin
            acks = int'({bus1.up_ack, bus1.cpu_ack, bus1.blt_ack});
            busy = int'(bus1.busy); we = int'(bus1.ram_we); gid = int'(bus1.grant_id);
            addr = int'(bus1.ram_addr); wd = int'(bus1.ram_wdata);
            crd = int'(bus1.cpu_rdata); brd = int'(bus1.blt_rdata);
        end else begin
            acks = int'({bus3.up_ack, bus3.cpu_ack, bus3.blt_ack});
            busy = int'(bus3.busy); we = int'(bus3.ram_we); gid = int'(bus3.grant_id);
            addr = int'(bus3.ram_addr); wd = int'(bus3.ram_wdata);
            crd = int'(bus3.cpu_rdata); brd = int'(bus3.blt_rdata);
        end
        check({tag, "_acks"}, acks, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ram_we"}, we, 0);
        check({tag, "_grant_id"}, gid, 0);
        check({tag, "_ram_addr"}, addr, 0);
        check({tag, "_ram_wdata"}, wd, 0);
        check({tag, "_cpu_rdata"}, crd, 0);
        check({tag, "_blt_rdata"}, brd, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int we_seen;
        int busy_seen;
        res = 1'b1;
        pl_we1 = 1'b0; pl_we3 = 1'b0; pl_addr = '0; pl_data = '0;
        bus1.uploading = 0; bus1.up_req = 0; bus1.up_addr = '0; bus1.up_wdata = '0;
        bus1.cpu_req = 0; bus1.cpu_we = 0; bus1.cpu_addr = '0; bus1.cpu_wdata = '0;
        bus1.blt_req = 0; bus1.blt_we = 0; bus1.blt_addr = '0; bus1.blt_wdata = '0;
        bus3.uploading = 0; bus3.up_req = 0; bus3.up_addr = '0; bus3.up_wdata = '0;
        bus3.cpu_req = 0; bus3.cpu_we = 0; bus3.cpu_addr = '0; bus3.cpu_wdata = '0;
        bus3.blt_req = 0; bus3.blt_we = 0; bus3.blt_addr = '0; bus3.blt_wdata = '0;

        preload(1, 'h200, 'hA2);
        preload(1, 'h201, 'h5B);
        preload(3, 'h0FF, 'h5A);
        preload(3, 'h100, 'hC3);
        check_reset(1, "reset1");
        check_reset(3, "reset3");
        res = 1'b0;
        @(negedge clk);

        // Fairness: both held, CPU first after reset, acks 3 cycles apart
        c = cyc;
        bus1.cpu_req = 1; bus1.cpu_we = 0; bus1.cpu_addr = 12'h200;
        bus1.blt_req = 1; bus1.blt_we = 0; bus1.blt_addr = 12'h201;
        push(1, 2, c + 3,  'hA2, 1);
        push(1, 3, c + 6,  'h5B, 1);
        push(1, 2, c + 9,  'hA2, 1);
        push(1, 3, c + 12, 'h5B, 1);
        repeat (12) @(negedge clk);
        bus1.cpu_req = 0; bus1.blt_req = 0;
        @(negedge clk);

        // Single CPU read: ack two edges after sampling, no write strobe
        c = cyc;
        bus1.cpu_req = 1; bus1.cpu_we = 0; bus1.cpu_addr = 12'h200;
        push(1, 2, c + 3, 'hA2, 1);
        we_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus1.ram_we) we_seen = 1;
        end
        bus1.cpu_req = 0;
        check("cpu_read_ram_we", we_seen, 0);
        @(negedge clk);

        // Upload vs CPU collision on the same address
        c = cyc;
        bus1.up_req = 1; bus1.up_addr = 12'h200; bus1.up_wdata = 8'h12;
        bus1.cpu_req = 1; bus1.cpu_we = 0; bus1.cpu_addr = 12'h200;
        push(1, 1, c + 3, 0, 0);
        push(1, 2, c + 6, 'h12, 1);
        fork
            begin wait_ack(1, 1, "coll_up_ack"); bus1.up_req = 0; end
            begin wait_ack(1, 2, "coll_cpu_ack"); bus1.cpu_req = 0; end
            begin
                @(negedge clk);
                check("coll_grant_up", int'(bus1.grant_id), 1);
                repeat (3) @(negedge clk);
                check("coll_grant_cpu", int'(bus1.grant_id), 2);
            end
        join
        @(negedge clk);

        // CPU write leaves cpu_rdata unchanged; blitter reads it back
        c = cyc;
        bus1.cpu_req = 1; bus1.cpu_we = 1; bus1.cpu_addr = 12'h210; bus1.cpu_wdata = 8'h3C;
        push(1, 2, c + 3, 'h12, 1);
        wait_ack(1, 2, "cpu_write_ack");
        bus1.cpu_req = 0; bus1.cpu_we = 0;
        @(negedge clk);
        c = cyc;
        bus1.blt_req = 1; bus1.blt_we = 0; bus1.blt_addr = 12'h210;
        push(1, 3, c + 3, 'h3C, 1);
        wait_ack(1, 3, "blt_read_ack");
        bus1.blt_req = 0;
        @(negedge clk);

        // Upload lockout
        bus1.uploading = 1;
        bus1.cpu_req = 1; bus1.cpu_we = 0; bus1.cpu_addr = 12'h201;
        busy_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus1.busy) busy_seen = 1;
        end
        check("lockout_busy", busy_seen, 0);
        c = cyc;
        bus1.uploading = 0;
        push(1, 2, c + 3, 'h5B, 1);
        wait_ack(1, 2, "lockout_release_ack");
        bus1.cpu_req = 0;
        @(negedge clk);

        // Reset during a blitter write
        bus1.blt_req = 1; bus1.blt_we = 1; bus1.blt_addr = 12'h300; bus1.blt_wdata = 8'h77;
        @(negedge clk);
        check("rst_pre_busy", int'(bus1.busy), 1);
        check("rst_pre_grant", int'(bus1.grant_id), 3);
        res = 1'b1;
        bus1.blt_req = 0; bus1.blt_we = 0;
        @(negedge clk);
        res = 1'b0;
        check_reset(1, "midreset");
        c = cyc;
        bus1.cpu_req = 1; bus1.cpu_we = 0; bus1.cpu_addr = 12'h201;
        bus1.blt_req = 1; bus1.blt_we = 0; bus1.blt_addr = 12'h300;
        push(1, 2, c + 3, 'h5B, 1);
        push(1, 3, c + 6, 'h77, 1);
        fork
            begin wait_ack(1, 2, "post_rst_cpu_ack"); bus1.cpu_req = 0; end
            begin wait_ack(1, 3, "post_rst_blt_ack"); bus1.blt_req = 0; end
        join
        @(negedge clk);

        // RAM_LAT=3: back-to-back reads, 5 cycles apart
        c = cyc;
        bus3.cpu_req = 1; bus3.cpu_we = 0; bus3.cpu_addr = 12'h0FF;
        push(3, 2, c + 5, 'h5A, 1);
        push(3, 2, c + 10, 'hC3, 1);
        wait_ack(3, 2, "lat3_first_ack");
        bus3.cpu_addr = 12'h100;
        wait_ack(3, 2, "lat3_second_ack");
        bus3.cpu_req = 0;

        repeat (4) @(negedge clk);
        check("pending_exp_d1", q1.size(), 0);
        check("pending_exp_d3", q3.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
